// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbitration controller: FSM states, width defaults
// and the opcode map presented to the external ALU.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_NOTB = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // 2-way round-robin pick: prio names the requester that wins a tie.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic prio);
        if (v0 && v1) begin
            return prio;
        end
        return v1;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter; the priority pointer only moves when the owner of the
// served operation is reported back through update/served.
module alu_rr_arb
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic gnt_valid,
    output logic gnt_id
);

    logic prio_q;

    // Last-served requester drops to lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (update) begin
            prio_q <= ~served;
        end
    end

    assign gnt_valid = req0 | req1;
    assign gnt_id    = rr_pick(req0, req1, prio_q);

endmodule

// File: rtl/alu_arb_ctrl.sv
// Shares one external combinational ALU between two requesters (IDLE/EXEC/RESP FSM).
// Define ALU_ARB_ZFLAG_EN to add the registered rsp_zero output.
module alu_arb_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_ARB_ZFLAG_EN
    output logic              rsp_zero,
`endif

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    state_e            state_q, state_d;
    logic              gnt_valid, gnt_id;
    logic              accept, rsp_done;
    logic [DATA_W-1:0] a_q, b_q, data_q;
    logic [OP_W-1:0]   op_q;
    logic              id_q;

    alu_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0_valid),
        .req1      (req1_valid),
        .update    (rsp_done),
        .served    (id_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // rst_n gates the grant so readies stay low while reset is held.
    assign accept   = (state_q == IDLE) && gnt_valid && rst_n;
    assign rsp_done = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers double as the ALU drive, so the ALU inputs only move on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= gnt_id ? req1_a  : req0_a;
            b_q  <= gnt_id ? req1_b  : req0_b;
            op_q <= gnt_id ? req1_op : req0_op;
            id_q <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (state_q == EXEC) begin
            data_q <= alu_result;
        end
    end

`ifdef ALU_ARB_ZFLAG_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state_q == EXEC) begin
            zero_q <= (alu_result == '0);
        end
    end

    assign rsp_zero = zero_q;
`endif

    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept &&  gnt_id;

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Self-checking bench for alu_arb_ctrl: behavioural ALU, response scoreboard and
// scenario tasks for arbitration, latency, stalls, wrap-around and reset.
module tb_alu_arb_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_data;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
`ifdef ALU_ARB_ZFLAG_EN
    logic       rsp_zero;
`endif

    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_arb_ctrl #(.DATA_W(4), .OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef ALU_ARB_ZFLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // External ALU; the reserved opcode computes XOR so pass-through is observable.
    always_comb begin
        alu_result = 4'h0;
        case (alu_op)
            OP_ZERO: alu_result = 4'h0;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOTA: alu_result = ~alu_a;
            OP_NOTB: alu_result = ~alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    // Scoreboard: every accepted response is popped and compared here.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, none expected", rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                if ({rsp_id, rsp_data} !== {mon_e.id, mon_e.data}) begin
                    miscompares++;
                    $display("FAIL rsp_scoreboard: got id=%0d data=%h, want id=%0d data=%h",
                             rsp_id, rsp_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'h3; req0_b = 4'h4; req0_op = OP_ADD;
        req1_a = 4'h5; req1_b = 4'h6; req1_op = OP_SUB;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy0,rdy1,vld,id=%b want 0000",
                     {req0_ready, req1_ready, rsp_valid, rsp_id});
        end
        vectors++;
        if ({rsp_data, alu_a, alu_b, alu_op} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%h a=%h b=%h op=%h want all 0",
                     rsp_data, alu_a, alu_b, alu_op);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        tick();
        req0_a = 4'h1; req0_b = 4'h2; req0_op = OP_ADD; req0_valid = 1'b1;
        req1_a = 4'h4; req1_b = 4'h4; req1_op = OP_ADD; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rr_first_after_reset: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h3});
        tick();
        // req0 immediately presents a new operation; req1 is still waiting.
        req0_a = 4'h7; req0_b = 4'h1;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL rr_ready_in_exec: got rdy=%b want 00", {req0_ready, req1_ready});
        end
        tick();
        tick();
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rr_second_grant: got rdy=%b want 01", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b1, 4'h8});
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rr_third_grant: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h8});
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        // Fresh tie after req0 was served last: req1 must win.
        req0_a = 4'h2; req0_b = 4'h2; req0_op = OP_AND; req0_valid = 1'b1;
        req1_a = 4'h9; req1_b = 4'h6; req1_op = OP_OR;  req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rr_tie_req1: got rdy=%b want 01", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b1, 4'hF});
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rr_tie_then_req0: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h2});
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_add_latency();
        tick();
        req0_a = 4'h3; req0_b = 4'h5; req0_op = OP_ADD; req0_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_accept: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h8});
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 4'h3, 4'h5, OP_ADD}) begin
            miscompares++;
            $display("FAIL add_exec: got vld=%b a=%h b=%h op=%h want 0,3,5,%h",
                     rsp_valid, alu_a, alu_b, alu_op, OP_ADD);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL add_latency_t2: got rsp_valid=%b want 1", rsp_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({rsp_valid, alu_a, alu_b} !== {1'b0, 4'h3, 4'h5}) begin
            miscompares++;
            $display("FAIL add_one_cycle_hold: got vld=%b a=%h b=%h want 0,3,5",
                     rsp_valid, alu_a, alu_b);
        end
    endtask

    task automatic test_wrap_stall();
        rsp_ready = 1'b0;
        tick();
        req1_a = 4'h2; req1_b = 4'h5; req1_op = OP_SUB; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL sub_accept: got rdy=%b want 01", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b1, 4'hD});
        tick();
        req1_valid = 1'b0;
        req0_a = 4'h6; req0_b = 4'h3; req0_op = OP_AND; req0_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {2'b11, 4'hD, 2'b00}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got vld=%b id=%b data=%h rdy=%b want 1,1,d,00",
                         i, rsp_valid, rsp_id, rsp_data, {req0_ready, req1_ready});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        vectors++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL stall_release_idle: got vld=%b rdy=%b want 0,10",
                     rsp_valid, {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h2});
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reserved_op();
        tick();
        req0_a = 4'hA; req0_b = 4'h6; req0_op = OP_RSVD; req0_valid = 1'b1;
        sb.push_back('{1'b0, 4'hC});
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (alu_op !== OP_RSVD) begin
            miscompares++;
            $display("FAIL rsvd_passthrough: got alu_op=%h want %h", alu_op, OP_RSVD);
        end
        tick();
        tick();
    endtask

`ifdef ALU_ARB_ZFLAG_EN
    task automatic test_zflag();
        tick();
        req1_a = 4'h4; req1_b = 4'h4; req1_op = OP_SUB; req1_valid = 1'b1;
        sb.push_back('{1'b1, 4'h0});
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL zflag_set: got rsp_zero=%b want 1", rsp_zero);
        end
        tick();
        req1_a = 4'h4; req1_b = 4'h1; req1_op = OP_OR; req1_valid = 1'b1;
        sb.push_back('{1'b1, 4'h5});
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL zflag_clear: got rsp_zero=%b want 0", rsp_zero);
        end
        tick();
    endtask
`endif

    task automatic test_reset_in_exec();
        tick();
        req0_a = 4'h5; req0_b = 4'h5; req0_op = OP_ADD; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_op} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_exec_clear: got vld=%b id=%b data=%h a=%h b=%h op=%h want all 0",
                     rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_op);
        end
        tick();
        tick();
        rst_n = 1'b1;
        req0_a = 4'h1; req0_b = 4'h1; req0_op = OP_ADD; req0_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_grant: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back('{1'b0, 4'h2});
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 4'h2}) begin
            miscompares++;
            $display("FAIL reset_then_add: got vld=%b data=%h want 1,2", rsp_valid, rsp_data);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_add_latency();
        test_wrap_stall();
        test_reserved_op();
`ifdef ALU_ARB_ZFLAG_EN
        test_zflag();
`endif
        test_reset_in_exec();
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending responses want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: operand and result width in bits.
REQ-002 Parameter OP_W, default 3: opcode width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  DATA_W  requester 0 operands.
REQ-008 req0_op  input  OP_W  requester 0 opcode, passed unchanged to the ALU.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-005..008, for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_data  output  DATA_W  registered ALU result.
REQ-014 alu_a, alu_b  output  DATA_W  operands driven to the external ALU.
REQ-015 alu_op  output  OP_W  opcode driven to the external ALU.
REQ-016 alu_result  input  DATA_W  combinational ALU result, sampled in EXEC.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready for that cycle only, latch its a/b/op and id, then go to EXEC.
REQ-019 Arbitration SHALL be round-robin: the last-served requester has lowest priority; after reset, requester 0 has priority.
REQ-020 Only the winner's ready SHALL be asserted; the loser's ready stays low, and its valid and operands must be held by the requester.
REQ-021 req0_ready and req1_ready SHALL be low in EXEC and RESP.
REQ-022 EXEC (one cycle): alu_a/alu_b/alu_op are driven from the latched registers, alu_result is captured into rsp_data, then go to RESP.
REQ-023 alu_a, alu_b and alu_op SHALL hold their last latched values outside EXEC (no toggling).
REQ-024 RESP: rsp_valid is high, and rsp_data and rsp_id are stable until the cycle in which rsp_ready is high. Then go to IDLE and update the round-robin pointer.
REQ-025 Latency: accept at cycle T, rsp_valid high at T+2. Peak throughput is one operation per 3 cycles.
REQ-026 The result SHALL be the raw DATA_W-bit ALU output: wrap-around modulo 2^DATA_W, no carry or borrow kept.
REQ-027 Opcodes SHALL NOT be checked; reserved codes pass through to the ALU.
REQ-028 If rsp_ready is already high on entry to RESP, rsp_valid SHALL last exactly one cycle.

Reset
REQ-029 rst_n low SHALL, asynchronously, force: state IDLE, round-robin pointer to requester 0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_op=0, both readies 0.
REQ-030 Reset in EXEC or RESP SHALL drop the in-flight operation with no response.
REQ-031 The first grant is possible in the first clock edge after rst_n deasserts.

Configuration
REQ-032 With ALU_ARB_ZFLAG_EN defined, add output rsp_zero (1 bit), registered with rsp_data in EXEC, high when the result is all zeros; reset value 0.
REQ-033 Without ALU_ARB_ZFLAG_EN, port rsp_zero and its register SHALL NOT exist; all other behaviour is unchanged.

Structure
REQ-034 Shared package alu_pkg SHALL hold the state enum (IDLE/EXEC/RESP), the DATA_W/OP_W defaults and the opcode constants (ZERO, ADD, SUB, AND, OR, NOTA, NOTB, RSVD).
REQ-035 A sub-module alu_rr_arb (2-way round-robin, pointer register inside) SHALL provide the grant; the FSM and datapath registers stay in alu_arb_ctrl.

Verification
REQ-036 req0: a=3, b=5, op=ADD at cycle T; bench ALU model -> rsp_valid at T+2, rsp_id=0, rsp_data=8.
REQ-037 Both valid in the same cycle after reset, req1 held -> req0 served first, then req1. Next simultaneous request -> req1 served first.
REQ-038 req1: a=2, b=5, op=SUB -> rsp_data=4'hD (wrap), rsp_id=1.
REQ-039 rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, no reqN_ready asserted; rsp_ready high -> IDLE next cycle.
REQ-040 rst_n low during EXEC -> all outputs 0 at once, no response. After release, a new req0 ADD 1+1 -> rsp_data=2.
REQ-041 With ALU_ARB_ZFLAG_EN: a=4, b=4, op=SUB -> rsp_data=0, rsp_zero=1. op=OR 4|1 -> rsp_zero=0.
